// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: canonical NOP, RV32 opcode[6:2] encodings and fetch FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ITYPE  = 5'b00100;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset_L,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Storage needs no reset: the head is only observed when the FIFO is non-empty.
  always_ff @(posedge i_clock) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues one imem request at a time, buffers responses and
// presents the head instruction plus its decode fields; redirects flush and drain stale fetches.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_L,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [4:0]      opcode,
  output logic [2:0]      funct3,
  output logic            instr30
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_target, w_target_nxt;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_push, w_pop, w_full, w_empty, w_credit_ok;
  logic [CNT_W-1:0]     w_count;
  logic [32+XLEN-1:0]   w_head;

  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
  // The only in-flight request is the one imem_req is holding, so a free slot covers it.
  assign w_credit_ok   = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_pop         = instr_valid && !stall && !redirect;
  assign imem_addr     = r_fetch_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    imem_req       = 1'b0;
    w_push         = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
        if (redirect) w_fetch_pc_nxt = w_redirect_pc;
      end
      S_FETCH: begin
        imem_req = w_credit_ok;
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            w_state_nxt  = S_DRAIN;
            w_target_nxt = w_redirect_pc;
          end else begin
            w_fetch_pc_nxt = w_redirect_pc;
          end
        end else if (imem_req && imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end
      end
      S_DRAIN: begin
        // Hold the stale request until its response arrives, then drop that response.
        imem_req = 1'b1;
        if (redirect) w_target_nxt = w_redirect_pc;
        if (imem_ack) begin
          w_state_nxt    = S_FETCH;
          w_fetch_pc_nxt = redirect ? w_redirect_pc : r_target;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32 + XLEN)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset_L   (reset_L),
    .i_push      (w_push),
    .i_push_data ({imem_rdata, r_fetch_pc}),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign instr_valid = !w_empty;
  assign instr       = w_empty ? NOP_INSTR : w_head[32+XLEN-1:XLEN];
  assign instr_pc    = w_empty ? RESET_PC  : w_head[XLEN-1:0];
  assign opcode      = instr[6:2];
  assign funct3      = instr[14:12];
  assign instr30     = instr[30];

  a_addr_stable: assert property (@(posedge clock) disable iff (!reset_L)
    imem_req && !imem_ack |=> imem_req && $stable(imem_addr));
  a_no_push_full: assert property (@(posedge clock) disable iff (!reset_L)
    w_push |-> !w_full);
  a_pc_aligned: assert property (@(posedge clock) disable iff (!reset_L)
    instr_valid |-> instr_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch sequencing, decode fields, stall back-pressure,
// redirect drain/flush, PC wrap and asynchronous reset mid-request.
module tb_instr_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W2   = 32'h0010_0093;
  localparam logic [31:0] W3   = 32'h0020_8113;

  logic            clock = 1'b0;
  logic            reset_L;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            instr30;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  instr_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .opcode      (opcode),
    .funct3      (funct3),
    .instr30     (instr30)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, "/req"}, 64'(imem_req), 64'(req));
    check_eq({tag, "/addr"}, 64'(imem_addr), 64'(addr));
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] ins,
                         input logic [31:0] pc);
    check_eq({tag, "/valid"}, 64'(instr_valid), 64'(vld));
    check_eq({tag, "/instr"}, 64'(instr), 64'(ins));
    check_eq({tag, "/pc"}, 64'(instr_pc), 64'(pc));
  endtask

  task automatic chk_fields(input string tag, input logic [4:0] op, input logic [2:0] f3,
                            input logic i30);
    check_eq({tag, "/opcode"}, 64'(opcode), 64'(op));
    check_eq({tag, "/funct3"}, 64'(funct3), 64'(f3));
    check_eq({tag, "/instr30"}, 64'(instr30), 64'(i30));
  endtask

  initial begin
    reset_L     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    #3;
    chk_req("rst", 1'b0, 32'h0);
    chk_out("rst", 1'b0, NOP, 32'h0);
    chk_fields("rst", 5'b00100, 3'b000, 1'b0);
    step();
    step();
    reset_L = 1'b1;
    chk_req("boot", 1'b0, 32'h0);

    // Sequential fetch, ack one cycle after each request, no stall.
    step();
    chk_req("c0", 1'b1, 32'h0);
    step();
    chk_req("c1_hold", 1'b1, 32'h0);
    chk_out("c1_empty", 1'b0, NOP, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0037;
    step();
    imem_ack = 1'b0;
    chk_out("lui", 1'b1, 32'h0000_0037, 32'h0);
    chk_fields("lui", 5'b01101, 3'b000, 1'b0);
    chk_req("c2", 1'b1, 32'h4);
    step();
    chk_out("pop0", 1'b0, NOP, 32'h0);
    chk_req("c3", 1'b1, 32'h4);
    imem_ack = 1'b1; imem_rdata = 32'h4000_5013;
    step();
    imem_ack = 1'b0;
    chk_out("srai", 1'b1, 32'h4000_5013, 32'h4);
    chk_fields("srai", 5'b00100, 3'b101, 1'b1);
    chk_req("c4", 1'b1, 32'h8);
    step();
    chk_out("pop1", 1'b0, NOP, 32'h0);

    // Stall six cycles with ack held high: only two words may be accepted.
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = W2;
    step();
    imem_rdata = W3;
    chk_out("stall_w2", 1'b1, W2, 32'h8);
    chk_req("stall_c6", 1'b1, 32'hC);
    step();
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk_req("full", 1'b0, 32'h10);
      chk_out("full", 1'b1, W2, 32'h8);
      step();
    end
    stall = 1'b0; imem_ack = 1'b0;
    chk_out("rel_w2", 1'b1, W2, 32'h8);
    chk_req("rel_c11", 1'b0, 32'h10);
    step();
    chk_out("rel_w3", 1'b1, W3, 32'hC);
    chk_req("rel_c12", 1'b1, 32'h10);
    step();
    chk_out("rel_empty", 1'b0, NOP, 32'h0);
    chk_req("rel_c13", 1'b1, 32'h10);

    // Redirect with a request outstanding: drain the stale response.
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk_req("drain0", 1'b1, 32'h10);
    chk_out("drain0", 1'b0, NOP, 32'h0);
    step();
    chk_req("drain1", 1'b1, 32'h10);
    step();
    chk_req("drain2", 1'b1, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_ack = 1'b0;
    chk_req("post_drain", 1'b1, 32'h100);
    chk_out("stale_drop", 1'b0, NOP, 32'h0);

    // Redirect together with ack and pop.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0037;
    step();
    chk_out("tgt_word", 1'b1, 32'h0000_0037, 32'h100);
    chk_req("tgt_c18", 1'b1, 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'h00BA_DBAD;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    chk_out("redir_ack_pop", 1'b0, NOP, 32'h0);
    chk_req("redir_ack_pop", 1'b1, 32'h200);

    // PC wrap from the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    redirect = 1'b0; imem_ack = 1'b0;
    chk_req("wrap_pre", 1'b1, 32'hFFFF_FFFC);
    chk_out("wrap_pre", 1'b0, NOP, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    imem_ack = 1'b0;
    chk_out("wrap_jal", 1'b1, 32'h0000_006F, 32'hFFFF_FFFC);
    chk_fields("wrap_jal", 5'b11011, 3'b000, 1'b0);
    chk_req("wrap_addr", 1'b1, 32'h0);

    // Asynchronous reset mid-request, then a stray ack during boot.
    #2;
    reset_L = 1'b0;
    #1;
    chk_req("async_rst", 1'b0, 32'h0);
    chk_out("async_rst", 1'b0, NOP, 32'h0);
    chk_fields("async_rst", 5'b00100, 3'b000, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    step();
    reset_L = 1'b1;
    chk_req("boot2", 1'b0, 32'h0);
    step();
    imem_ack = 1'b0;
    chk_out("stray_ack", 1'b0, NOP, 32'h0);
    chk_req("boot2_fetch", 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
